// File: rtl/plic_pkg.sv
// Shared types and constants for the PLIC gateway bank.
// Holds the gateway state encoding, edge counter limit and ID width helper.
package plic_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    INFLIGHT = 2'd2
  } gw_state_e;

  // Saturation limit of the per-source rising-edge counter
  localparam int unsigned EDGE_CNT_MAX = 3;

  // Width needed to encode IDs 0..n, where ID 0 means "no source"
  function automatic int id_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// Single-source PLIC gateway: IDLE -> PENDING -> INFLIGHT -> IDLE.
// Ports: clock, reset (sync, active-high), src, claim_hit, complete_hit,
//   edge_mode (only with PLIC_EDGE_TRIG_EN), ip, inflight (both registered).
// Optional feature macro: PLIC_EDGE_TRIG_EN (rising-edge counting mode).
module plic_gateway
  import plic_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic src,
  input  logic claim_hit,
  input  logic complete_hit,
`ifdef PLIC_EDGE_TRIG_EN
  input  logic edge_mode,
`endif
  output logic ip,
  output logic inflight
);

  gw_state_e state_q, state_d;
  logic      ip_q;
  logic      inflight_q;
  logic      req;

`ifdef PLIC_EDGE_TRIG_EN
  logic       prev_q;
  logic [1:0] cnt_q, cnt_d;
  logic       rise;
  logic       taken;

  assign rise  = src & ~prev_q;
  // An accepted claim of an edge-mode source consumes one edge
  assign taken = claim_hit & edge_mode
               & (state_q == PENDING);

  always_comb begin
    cnt_d = cnt_q;
    if (rise && !taken) begin
      if (cnt_q != 2'(EDGE_CNT_MAX))
        cnt_d = cnt_q + 2'd1;
    end else if (taken && !rise) begin
      if (cnt_q != 2'd0)
        cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      prev_q <= src;
      cnt_q  <= cnt_d;
    end
  end

  assign req = edge_mode ? (cnt_q != 2'd0) : src;
`else
  assign req = src;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (req)          state_d = PENDING;
      PENDING:  if (claim_hit)    state_d = INFLIGHT;
      INFLIGHT: if (complete_hit) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Outputs are flopped from the next state so they carry no
  // combinational path from any input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ip_q       <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ip_q       <= (state_d == PENDING);
      inflight_q <= (state_d == INFLIGHT);
    end
  end

  assign ip       = ip_q;
  assign inflight = inflight_q;

endmodule

// File: rtl/plic_gateway_bank.sv
// Bank of NUM_SOURCES PLIC gateways with claim/complete ID decode.
// Ports: clock, reset (sync, active-high), io_src, io_claim_valid/id,
//   io_complete_valid/id, io_ip, io_inflight; io_edge_mode only when
//   PLIC_EDGE_TRIG_EN is defined. Source ID i maps to bit i-1.
module plic_gateway_bank
  import plic_pkg::*;
#(
  parameter int NUM_SOURCES = 8,
  parameter int ID_W        = id_width(NUM_SOURCES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] io_src,
`ifdef PLIC_EDGE_TRIG_EN
  input  logic [NUM_SOURCES-1:0] io_edge_mode,
`endif
  input  logic                   io_claim_valid,
  input  logic [ID_W-1:0]        io_claim_id,
  input  logic                   io_complete_valid,
  input  logic [ID_W-1:0]        io_complete_id,
  output logic [NUM_SOURCES-1:0] io_ip,
  output logic [NUM_SOURCES-1:0] io_inflight
);

  logic [NUM_SOURCES-1:0] claim_hit;
  logic [NUM_SOURCES-1:0] complete_hit;

  // ID 0 and IDs above NUM_SOURCES match no bit and fall away here
  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_gw
    assign claim_hit[i] = io_claim_valid
      && (io_claim_id == ID_W'(i + 1));
    assign complete_hit[i] = io_complete_valid
      && (io_complete_id == ID_W'(i + 1));

    plic_gateway u_gw (
      .clock        (clock),
      .reset        (reset),
      .src          (io_src[i]),
      .claim_hit    (claim_hit[i]),
      .complete_hit (complete_hit[i]),
`ifdef PLIC_EDGE_TRIG_EN
      .edge_mode    (io_edge_mode[i]),
`endif
      .ip           (io_ip[i]),
      .inflight     (io_inflight[i])
    );
  end

endmodule

// File: tb/tb_plic_gateway_bank.sv
// Self-checking bench for plic_gateway_bank: directed table,
// randomized run against a reference model, edge-mode sequence.
module tb_plic_gateway_bank;

  localparam int N = 8;
  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] io_src;
  logic         io_claim_valid;
  logic [W-1:0] io_claim_id;
  logic         io_complete_valid;
  logic [W-1:0] io_complete_id;
  logic [N-1:0] io_ip;
  logic [N-1:0] io_inflight;
`ifdef PLIC_EDGE_TRIG_EN
  logic [N-1:0] io_edge_mode;
`endif

  always #5 clock = ~clock;

  plic_gateway_bank #(
    .NUM_SOURCES (N),
    .ID_W        (W)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .io_src            (io_src),
`ifdef PLIC_EDGE_TRIG_EN
    .io_edge_mode      (io_edge_mode),
`endif
    .io_claim_valid    (io_claim_valid),
    .io_claim_id       (io_claim_id),
    .io_complete_valid (io_complete_valid),
    .io_complete_id    (io_complete_id),
    .io_ip             (io_ip),
    .io_inflight       (io_inflight)
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] src;
    logic         cv;
    logic [W-1:0] cid;
    logic         kv;
    logic [W-1:0] kid;
    logic [N-1:0] ip;
    logic [N-1:0] inf;
  } vec_t;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference: per-source pending / claimed flags
  bit mp[N];
  bit mf[N];

  task automatic chk(input string nm,
                     input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic r, input logic [N-1:0] s,
                       input logic cv, input logic [W-1:0] cid,
                       input logic kv, input logic [W-1:0] kid);
    reset             = r;
    io_src            = s;
    io_claim_valid    = cv;
    io_claim_id       = cid;
    io_complete_valid = kv;
    io_complete_id    = kid;
  endtask

  function automatic vec_t mk(
    logic r, logic [N-1:0] s, logic cv, logic [W-1:0] cid,
    logic kv, logic [W-1:0] kid, logic [N-1:0] ip,
    logic [N-1:0] inf);
    vec_t v;
    v.rst = r; v.src = s; v.cv = cv; v.cid = cid;
    v.kv = kv; v.kid = kid; v.ip = ip; v.inf = inf;
    return v;
  endfunction

  // Apply one edge of the rules to the model from current inputs
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int id;
      id = i + 1;
      if (reset) begin
        mp[i] = 0;
        mf[i] = 0;
      end else if (mf[i]) begin
        if (io_complete_valid && int'(io_complete_id) == id)
          mf[i] = 0;
      end else if (mp[i]) begin
        if (io_claim_valid && int'(io_claim_id) == id) begin
          mp[i] = 0;
          mf[i] = 1;
        end
      end else if (io_src[i]) begin
        mp[i] = 1;
      end
    end
  endtask

  function automatic logic [N-1:0] pk(bit a[N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
`ifdef PLIC_EDGE_TRIG_EN
    io_edge_mode = '0;
`endif
    drive(1, 0, 0, 0, 0, 0);

    //          rst src   cv cid kv kid  ip    inf
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 8'h04, 0, 0, 0, 0, 8'h04, 8'h00));
    tbl.push_back(mk(0, 8'h04, 1, 3, 0, 0, 8'h00, 8'h04));
    tbl.push_back(mk(0, 8'h04, 0, 0, 0, 0, 8'h00, 8'h04));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h04));
    tbl.push_back(mk(0, 8'h04, 0, 0, 0, 0, 8'h00, 8'h04));
    tbl.push_back(mk(0, 8'h04, 0, 0, 1, 3, 8'h00, 8'h00));
    tbl.push_back(mk(0, 8'h04, 0, 0, 0, 0, 8'h04, 8'h00));
    tbl.push_back(mk(0, 8'h14, 1, 0, 0, 0, 8'h14, 8'h00));
    tbl.push_back(mk(0, 8'h14, 1, 9, 0, 0, 8'h14, 8'h00));
    tbl.push_back(mk(0, 8'h14, 0, 0, 1, 5, 8'h14, 8'h00));
    tbl.push_back(mk(0, 8'h14, 1, 3, 1, 5, 8'h10, 8'h04));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 8'h09, 0, 0, 0, 0, 8'h09, 8'h00));
    tbl.push_back(mk(0, 8'h09, 1, 1, 0, 0, 8'h08, 8'h01));
    tbl.push_back(mk(0, 8'h00, 1, 4, 1, 1, 8'h00, 8'h08));
    tbl.push_back(mk(0, 8'h00, 1, 4, 1, 4, 8'h00, 8'h00));
    tbl.push_back(mk(0, 8'h81, 0, 0, 0, 0, 8'h81, 8'h00));
    tbl.push_back(mk(0, 8'h81, 1, 1, 0, 0, 8'h80, 8'h01));
    tbl.push_back(mk(0, 8'h81, 1, 8, 0, 0, 8'h00, 8'h81));
    tbl.push_back(mk(1, 8'h01, 1, 1, 1, 1, 8'h00, 8'h00));
    tbl.push_back(mk(0, 8'h01, 0, 0, 0, 0, 8'h01, 8'h00));
    tbl.push_back(mk(0, 8'h01, 1, 15, 0, 0, 8'h01, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h01, 8'h00));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 8'h01));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h00, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].src, tbl[k].cv,
            tbl[k].cid, tbl[k].kv, tbl[k].kid);
      tick();
      chk($sformatf("vec%0d_ip", k), io_ip, tbl[k].ip);
      chk($sformatf("vec%0d_inf", k), io_inflight, tbl[k].inf);
    end

    // Randomized run against the reference model
    drive(1, 0, 0, 0, 0, 0);
    model_step();
    tick();
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] flip;
      flip = N'($urandom) & N'($urandom);
      drive($urandom_range(0, 59) == 0,
            io_src ^ flip,
            1'($urandom),
            W'($urandom_range(0, 9)),
            1'($urandom),
            W'($urandom_range(0, 9)));
      model_step();
      tick();
      chk("rand_ip", io_ip, pk(mp));
      chk("rand_inf", io_inflight, pk(mf));
    end

`ifdef PLIC_EDGE_TRIG_EN
    // Four pulses saturate the edge counter at three
    io_edge_mode = 8'h01;
    drive(1, 0, 0, 0, 0, 0);
    tick();
    reset = 0;
    for (int p = 0; p < 4; p++) begin
      io_src = 8'h01;
      tick();
      io_src = 8'h00;
      tick();
    end
    chk("edge_pend", io_ip, 8'h01);
    for (int r = 0; r < 3; r++) begin
      drive(0, 0, 1, 1, 0, 0);
      tick();
      chk("edge_claim", io_inflight, 8'h01);
      drive(0, 0, 0, 0, 1, 1);
      tick();
      chk("edge_done", io_inflight, 8'h00);
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk("edge_repend", io_ip, (r < 2) ? 8'h01 : 8'h00);
    end
    tick();
    chk("edge_empty", io_ip, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
